// File: rtl/abs_dif_arbiter.sv
// Two-requester round-robin front end sharing one combinational |a-b| unit.
// One transaction in flight at a time: IDLE accepts, CALC computes, RESP holds the result.

module abs_dif (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);
    assign y = (a >= b) ? (a - b) : (b - a);
endmodule

module abs_dif_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_out,
    output logic             rsp_id,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic       id_q, id_d;
    logic [3:0] rsp_out_q, rsp_out_d;
    logic       rsp_id_q, rsp_id_d;
    logic       rsp_valid_q, rsp_valid_d;

    logic       grant0, grant1;
    logic       rsp_fire;
    logic [3:0] abs_y;
    logic [1:0][CNT_W-1:0] cnt_all;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            grant0 = req0_valid && (!req1_valid || last_q);
            grant1 = req1_valid && (!req0_valid || !last_q);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_fire   = (state_q == RESP) && rsp_ready;

    abs_dif u_abs_dif (
        .a (a_q),
        .b (b_q),
        .y (abs_y)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_out_d   = rsp_out_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (grant0) begin
                    a_d     = req0_a;
                    b_d     = req0_b;
                    id_d    = 1'b0;
                    state_d = CALC;
                end else if (grant1) begin
                    a_d     = req1_a;
                    b_d     = req1_b;
                    id_d    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                rsp_out_d   = abs_y;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    last_d      = rsp_id_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            id_q        <= 1'b0;
            rsp_out_q   <= 4'd0;
            rsp_id_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_out_q   <= rsp_out_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Per-requester saturating service counters, bumped on the response handshake.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (rsp_fire && (rsp_id_q == 1'(gi)) && (cnt_q != {CNT_W{1'b1}}))
                    cnt_d = cnt_q + CNT_W'(1);
            end

            always_ff @(posedge clk) begin
                if (!rst_n) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end

            assign cnt_all[gi] = cnt_q;
        end
    endgenerate

    assign cnt0      = cnt_all[0];
    assign cnt1      = cnt_all[1];
    assign rsp_valid = rsp_valid_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_abs_dif_arbiter.sv
// Bench for abs_dif_arbiter: transaction-level model checked every cycle plus directed literal checks.

module tb_abs_dif_arbiter;
    logic       clk = 1'b0;
    logic       rst_n, req0_valid, req1_valid, rsp_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [3:0] rsp_out;
    logic [7:0] cnt0, cnt1;
    logic       s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_busy;
    logic [3:0] s_rsp_out;
    logic [1:0] s_cnt0, s_cnt1;

    always #5 clk = ~clk;

    abs_dif_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_id(rsp_id),
        .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    abs_dif_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(s_req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(s_req1_ready),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_out(s_rsp_out), .rsp_id(s_rsp_id),
        .busy(s_busy), .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cycle = 0;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Transaction model: a pending job with its age in cycles since acceptance.
    bit m_known = 0, m_pend = 0, m_last = 1, m_id = 0;
    int m_age = 0, m_res = 0;
    int m_cnt [2] = '{0, 0};

    always @(posedge clk) begin
        if (!rst_n) begin
            m_known = 1; m_pend = 0; m_last = 1; m_cnt = '{0, 0};
        end else if (m_known) begin
            if (!m_pend) begin
                if (req0_valid && (!req1_valid || m_last)) begin
                    m_pend = 1; m_age = 1; m_id = 0; m_res = absd(req0_a, req0_b);
                end else if (req1_valid && (!req0_valid || !m_last)) begin
                    m_pend = 1; m_age = 1; m_id = 1; m_res = absd(req1_a, req1_b);
                end
            end else if (m_age >= 2 && rsp_ready) begin
                m_pend = 0;
                m_last = m_id;
                if (m_cnt[m_id] < 255) m_cnt[m_id]++;
                $display("rsp id=%0d out=%0d cnt=%0d at cycle %0d", m_id, m_res, m_cnt[m_id], cycle);
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known && rst_n) begin
            bit e_g0, e_g1, e_v;
            e_g0 = !m_pend && req0_valid && (!req1_valid || m_last);
            e_g1 = !m_pend && req1_valid && (!req0_valid || !m_last);
            e_v  = m_pend && (m_age >= 2);
            check("m_ready0", req0_ready, e_g0);
            check("m_ready1", req1_ready, e_g1);
            check("m_valid", rsp_valid, e_v);
            check("m_busy", busy, m_pend);
            check("m_cnt0", cnt0, m_cnt[0]);
            check("m_cnt1", cnt1, m_cnt[1]);
            check("m_sat_ready0", s_req0_ready, e_g0);
            check("m_sat_valid", s_rsp_valid, e_v);
            check("m_sat_cnt0", s_cnt0, (m_cnt[0] > 3) ? 3 : m_cnt[0]);
            check("m_sat_cnt1", s_cnt1, (m_cnt[1] > 3) ? 3 : m_cnt[1]);
            if (e_v) begin
                check("m_out", rsp_out, m_res);
                check("m_id", rsp_id, m_id);
                check("m_sat_out", s_rsp_out, m_res);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic wait_ready(input bit id, output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    task automatic run_single(input bit id, input logic [3:0] a, input logic [3:0] b, input int exp);
        bit ok;
        rsp_ready = 1;
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; end
        wait_ready(id, ok);
        tick();
        req0_valid = 0;
        req1_valid = 0;
        if (!ok) return;
        @(negedge clk);
        check("calc_valid", rsp_valid, 0);
        check("calc_busy", busy, 1);
        tick();
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_out", rsp_out, exp);
        check("rsp_id", rsp_id, id);
        tick();
        @(negedge clk);
        check("idle_busy", busy, 0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    logic [3:0] pa0 [4] = '{4'd1, 4'd14, 4'd7, 4'd0};
    logic [3:0] pb0 [4] = '{4'd9, 4'd2, 4'd7, 4'd15};
    logic [3:0] pa1 [4] = '{4'd6, 4'd3, 4'd15, 4'd8};
    logic [3:0] pb1 [4] = '{4'd1, 4'd11, 4'd0, 4'd8};

    initial begin
        bit ok, found, drop;
        int i0, i1;
        int gseq [$];
        int acc [$];

        rst_n = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        tick(); tick();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_out", rsp_out, 0);
        check("rst_id", rsp_id, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
        check("rst_ready0", req0_ready, 0);
        tick();
        rst_n = 1;

        run_single(0, 4'd3, 4'd12, 9);
        run_single(1, 4'd10, 4'd4, 6);
        run_single(0, 4'd5, 4'd5, 0);
        run_single(1, 4'd12, 4'd0, 12);
        run_single(0, 4'd0, 4'd15, 15);
        run_single(1, 4'd15, 4'd0, 15);
        @(negedge clk);
        check("single_cnt0", cnt0, 3);
        check("single_cnt1", cnt1, 3);
        tick();

        // Both requesters valid continuously.
        do_reset();
        rsp_ready = 1;
        i0 = 0; i1 = 0;
        req0_valid = 1; req0_a = pa0[0]; req0_b = pb0[0];
        req1_valid = 1; req1_a = pa1[0]; req1_b = pb1[0];
        for (int k = 0; k < 80 && (i0 < 4 || i1 < 4); k++) begin
            @(negedge clk);
            if (req0_valid && req0_ready === 1'b1) begin gseq.push_back(0); acc.push_back(cycle); i0++; end
            else if (req1_valid && req1_ready === 1'b1) begin gseq.push_back(1); acc.push_back(cycle); i1++; end
            tick();
            req0_valid = (i0 < 4);
            req1_valid = (i1 < 4);
            if (i0 < 4) begin req0_a = pa0[i0]; req0_b = pb0[i0]; end
            if (i1 < 4) begin req1_a = pa1[i1]; req1_b = pb1[i1]; end
        end
        check("both_grants", gseq.size(), 8);
        foreach (gseq[i]) check($sformatf("grant_%0d", i), gseq[i], i % 2);
        for (int i = 1; i < acc.size(); i++) check($sformatf("period_%0d", i), acc[i] - acc[i-1], 3);
        tick(); tick(); tick();
        @(negedge clk);
        check("both_cnt0", cnt0, 4);
        check("both_cnt1", cnt1, 4);
        tick();

        // Backpressure in RESP with requester 0 waiting.
        rsp_ready = 0;
        req1_valid = 1; req1_a = 4'd7; req1_b = 4'd2;
        wait_ready(1, ok);
        tick();
        req1_valid = 0;
        req0_valid = 1; req0_a = 4'd3; req0_b = 4'd3;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_out", rsp_out, 5);
            check("bp_id", rsp_id, 1);
            check("bp_ready0", req0_ready, 0);
            check("bp_ready1", req1_ready, 0);
            check("bp_busy", busy, 1);
            tick();
        end
        rsp_ready = 1;
        req0_valid = 0;
        @(negedge clk);
        check("bp_release_valid", rsp_valid, 1);
        tick();
        @(negedge clk);
        check("bp_idle_busy", busy, 0);
        check("bp_idle_valid", rsp_valid, 0);
        check("bp_cnt1", cnt1, 5);
        tick();

        // Requester 1 changes operands while requester 0 is served.
        do_reset();
        rsp_ready = 1;
        req0_valid = 1; req0_a = 4'd2; req0_b = 4'd3;
        req1_valid = 1; req1_a = 4'd1; req1_b = 4'd9;
        wait_ready(0, ok);
        tick();
        req0_valid = 0;
        req1_a = 4'd9; req1_b = 4'd1;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drop = (req1_ready === 1'b1);
            if (rsp_valid === 1'b1 && rsp_id === 1'b1) begin
                found = 1;
                check("chg_out", rsp_out, 8);
                break;
            end
            tick();
            if (drop) req1_valid = 0;
        end
        if (!found) check("chg_timeout", 0, 1);
        tick();
        tick();

        // Reset while in CALC drops the transaction.
        req0_valid = 1; req0_a = 4'd4; req0_b = 4'd1;
        wait_ready(0, ok);
        tick();
        req0_valid = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        @(negedge clk);
        check("rc_busy", busy, 0);
        check("rc_valid", rsp_valid, 0);
        check("rc_cnt0", cnt0, 0);
        check("rc_cnt1", cnt1, 0);
        tick();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rc_no_rsp", rsp_valid, 0);
            tick();
        end

        // Saturation of a 2-bit counter.
        do_reset();
        for (int k = 1; k <= 5; k++) run_single(0, 4'(k), 4'd0, k);
        @(negedge clk);
        check("sat_cnt0", s_cnt0, 3);
        check("wide_cnt0", cnt0, 5);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/abs_dif_arbiter.md
# abs_dif_arbiter

Round-robin arbiter and sequencer sharing one combinational `abs_dif` unit (4-bit |a−b|) between two requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester, registers its operands, and computes through a single `abs_dif` instance. It returns the result with the requester ID over a valid/ready response channel and keeps per-requester service counters. It sits between the operand sources and the shared arithmetic unit in the datapath.

## Interface
- `CNT_W`, default 8: width of each service counter.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req0_valid`  in  1  requester 0 has an operand pair.
- `req0_a`, `req0_b`  in  4  requester 0 operands, unsigned.
- `req0_ready`  out  1  requester 0 pair is accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_out`  out  4  |a−b| of the granted pair.
- `rsp_id`  out  1  requester that owns `rsp_out`.
- `busy`  out  1  high whenever the state is not IDLE.
- `cnt0`, `cnt1`  out  CNT_W  completed responses per requester; saturate at 2^CNT_W−1.

## Operation
- FSM states are IDLE, CALC and RESP. The state register is the only place a transaction lives; there is no queue.
- IDLE:
  - Grant: if exactly one `reqN_valid` is high, grant it. If both are high, grant the requester ≠ `last`.
  - Ready: `reqN_ready` is high combinationally for the granted requester only. The two readies are never high together, and both are low outside IDLE.
  - On valid&ready, latch a, b and the ID into operand registers, then go to CALC. If neither valid is high, stay in IDLE.
- CALC: the operand registers drive the single `abs_dif` instance. Its output is registered into `rsp_out`, the latched ID goes to `rsp_id`, `rsp_valid` is set, and the FSM goes to RESP.
- RESP:
  - `rsp_valid`, `rsp_out` and `rsp_id` hold stable until `rsp_ready` is high.
  - On handshake: clear `rsp_valid`, set `last` ← `rsp_id`, increment `cnt[rsp_id]` unless it is saturated, and go to IDLE.
- Arithmetic is unsigned 4-bit, so the result is always within 0..15. Equal operands give 0.
- A requester may drop valid or change operands while not granted. Only the values present on the handshake cycle are used.
- Reset (`rst_n`=0 at a rising edge), from any state including mid-transaction:
  - State → IDLE, `last` ← 1, so requester 0 wins the first tie.
  - `rsp_valid`, `rsp_out`, `rsp_id`, `cnt0` and `cnt1` → 0, and `busy` → 0.
  - Any in-flight transaction is dropped and produces no response.

## Timing
- Request accepted at the edge ending cycle T (IDLE, valid&ready).
- Cycle T+1 is CALC. `rsp_valid` rises at cycle T+2, giving a latency of 2 cycles.
- If `rsp_ready` is high at T+2, the FSM is back in IDLE at T+3, where the next request can be accepted.
- Peak throughput is one operation per 3 cycles. Each cycle `rsp_ready` stays low adds one cycle.
- Counters update on the response-handshake edge and are visible the following cycle.
- `busy` is high during CALC and RESP.
- `reqN_ready` depends only on state, `last` and both valids; there is no combinational path from `rsp_ready`.

## Test plan
- Single requests with `rsp_ready`=1:
  - req0 (3,12) → `rsp_out`=9, `rsp_id`=0, two cycles after acceptance.
  - req1 (10,4) → 6, id 1.
  - req0 (5,5) → 0.
  - req1 (12,0) → 12.
  - Boundary pairs (0,15) and (15,0) → 15.
- Both valid continuously, 4 pairs each, `rsp_ready`=1:
  - Grants alternate 0,1,0,1,… starting with 0 after reset.
  - Ends with `cnt0`=`cnt1`=4.
  - Exactly one operation per 3 cycles.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_out`/`rsp_id` stable, both readies low, `busy`=1. Release → one handshake, then back to IDLE.
- Requester changes its operands from (1,9) to (9,1) while the other requester is being served. The later grant returns |9−1|=8, using the handshake-cycle values.
- Assert reset in CALC → next cycle state IDLE, `rsp_valid`=0, counters 0, and no response ever appears for the dropped pair.
- With `CNT_W`=2, complete 5 req0 transactions → `cnt0` saturates at 3.
